// File: rtl/prefetch_unit.sv
// Instruction prefetch unit: ring of fetch slots with reserve/fill/drain pointers,
// redirect flush with in-flight response dropping, and a direct-mapped BTB predictor.
module prefetch_unit #(
  parameter int unsigned      XLEN        = 32,
  parameter logic [XLEN-1:0]  RESET_PC    = 32'h00000040,
  parameter int unsigned      QDEPTH      = 4,
  parameter int unsigned      BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            btb_upd_valid,
  input  logic [XLEN-1:0] btb_upd_pc,
  input  logic [XLEN-1:0] btb_upd_target,
  input  logic            btb_upd_taken,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_ins,
  output logic            id_predict_taken,
  output logic [XLEN-1:0] id_predict_target
);
  localparam int unsigned QW = $clog2(QDEPTH);
  localparam int unsigned PW = QW + 1;
  localparam int unsigned DW = PW + 1;
  localparam int unsigned BW = $clog2(BTB_ENTRIES);
  localparam int unsigned TW = XLEN - BW - 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
  } slot_t;

  slot_t           slot_q [QDEPTH];
  logic [31:0]     ins_q  [QDEPTH];
  logic [XLEN-1:0] pc;
  logic [PW-1:0]   wptr, fptr, rptr, used, unfilled;
  logic [DW-1:0]   drop_cnt, drop_nxt;
  logic            issue, fill, drain, rsp_sub;

  logic [BTB_ENTRIES-1:0] btb_v;
  logic [TW-1:0]          btb_tag [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_tgt [BTB_ENTRIES];
  logic [1:0]             btb_ctr [BTB_ENTRIES];
  logic [BW-1:0]          lk_idx, up_idx;
  logic                   lk_hit, up_hit, pred_taken;
  logic [XLEN-1:0]        pc_plus4, pred_target;
  logic [1:0]             up_ctr_nxt;
  logic                   unused_addr_lsbs;

  assign unused_addr_lsbs = ^{redirect_pc[1:0], btb_upd_pc[1:0]};

  // BTB lookup on the current fetch pc
  assign lk_idx      = pc[BW+1:2];
  assign lk_hit      = btb_v[lk_idx] && (btb_tag[lk_idx] == pc[XLEN-1:BW+2]);
  assign pred_taken  = lk_hit && btb_ctr[lk_idx][1];
  assign pc_plus4    = pc + XLEN'(4);
  assign pred_target = pred_taken ? btb_tgt[lk_idx] : pc_plus4;

  assign up_idx = btb_upd_pc[BW+1:2];
  assign up_hit = btb_v[up_idx] && (btb_tag[up_idx] == btb_upd_pc[XLEN-1:BW+2]);
  always_comb begin
    up_ctr_nxt = btb_ctr[up_idx];
    if (btb_upd_taken) begin
      if (btb_ctr[up_idx] != 2'b11) up_ctr_nxt = btb_ctr[up_idx] + 2'b01;
    end else begin
      if (btb_ctr[up_idx] != 2'b00) up_ctr_nxt = btb_ctr[up_idx] - 2'b01;
    end
  end

  assign used           = wptr - rptr;
  assign unfilled       = wptr - fptr;
  assign imem_req_valid = rst_n && !redirect_valid && (drop_cnt == '0) && (used < PW'(QDEPTH));
  assign imem_req_addr  = {pc[XLEN-1:2], 2'b00};
  assign issue          = imem_req_valid && imem_req_ready;
  assign fill           = imem_rsp_valid && !redirect_valid && (drop_cnt == '0) && (unfilled != '0);
  assign id_valid       = (rptr != fptr) && !redirect_valid;
  assign drain          = id_valid && id_ready;

  // A response arriving in the redirect cycle belongs to the old stream and is consumed here
  assign rsp_sub  = imem_rsp_valid && ((drop_cnt != '0) || (unfilled != '0));
  assign drop_nxt = drop_cnt + DW'(unfilled) - DW'(rsp_sub);

  assign id_pc             = slot_q[rptr[QW-1:0]].pc;
  assign id_predict_taken  = slot_q[rptr[QW-1:0]].taken;
  assign id_predict_target = slot_q[rptr[QW-1:0]].target;
  assign id_ins            = ins_q[rptr[QW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      wptr     <= '0;
      fptr     <= '0;
      rptr     <= '0;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      pc       <= {redirect_pc[XLEN-1:2], 2'b00};
      wptr     <= '0;
      fptr     <= '0;
      rptr     <= '0;
      drop_cnt <= drop_nxt;
    end else begin
      if (issue) begin
        pc   <= pred_target;
        wptr <= wptr + 1'b1;
      end
      if (fill)  fptr <= fptr + 1'b1;
      if (drain) rptr <= rptr + 1'b1;
      if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) slot_q[wptr[QW-1:0]] <= '{pc: pc, taken: pred_taken, target: pred_target};
    if (fill)  ins_q[fptr[QW-1:0]]  <= imem_rsp_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              btb_v         <= '0;
    else if (btb_upd_valid && btb_upd_taken) btb_v[up_idx] <= 1'b1;
  end

  // Not-taken misses leave the entry untouched; taken updates (re)write tag and target
  always_ff @(posedge clk) begin
    if (btb_upd_valid) begin
      if (btb_upd_taken) begin
        btb_tag[up_idx] <= btb_upd_pc[XLEN-1:BW+2];
        btb_tgt[up_idx] <= btb_upd_target;
      end
      if (up_hit)             btb_ctr[up_idx] <= up_ctr_nxt;
      else if (btb_upd_taken) btb_ctr[up_idx] <= 2'b10;
    end
  end
endmodule

// File: tb/tb_prefetch_unit.sv
// Randomized scoreboard bench for prefetch_unit: an in-order memory model, a
// stream-level fetch/BTB reference model, and a decode-side monitor.
module tb_prefetch_unit;
  localparam int          QDEPTH   = 4;
  localparam logic [31:0] RESET_PC = 32'h40;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        redirect_valid = 0, btb_upd_valid = 0, btb_upd_taken = 0;
  logic [31:0] redirect_pc = 0, btb_upd_pc = 0, btb_upd_target = 0;
  logic        imem_req_valid, imem_req_ready = 0, imem_rsp_valid = 0;
  logic [31:0] imem_req_addr, imem_rsp_data = 0;
  logic        id_valid, id_ready = 0, id_predict_taken;
  logic [31:0] id_pc, id_ins, id_predict_target;

  always #5 clk = ~clk;

  prefetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .QDEPTH(QDEPTH), .BTB_ENTRIES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .btb_upd_valid(btb_upd_valid), .btb_upd_pc(btb_upd_pc),
    .btb_upd_target(btb_upd_target), .btb_upd_taken(btb_upd_taken),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_ins(id_ins),
    .id_predict_taken(id_predict_taken), .id_predict_target(id_predict_target)
  );

  typedef struct { logic [31:0] pc; logic [31:0] ins; bit taken; logic [31:0] tgt; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  exp_t  exp_q[$];
  mreq_t mem_q[$];
  int    checks = 0, passes = 0, cyc = 0, issues = 0, handshakes = 0, hs0;

  // reference model state: fetch stream pc, pending drops, BTB contents
  logic [31:0] m_pc = RESET_PC, last_issue = 0;
  int          m_drop = 0;
  bit          bv[16];
  logic [31:0] btag[16], btgt[16];
  int          bctr[16];

  int p_redir = 0, p_idr = 100, p_mrdy = 100, p_btb = 0, max_lat = 1;
  bit d_use = 0, d_redir = 0, d_upd = 0, d_utk = 0, saw_200 = 0, saw_4c = 0;
  logic [31:0] d_rpc = 0, d_upc = 0, d_utgt = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h12345678;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic predict(input logic [31:0] pc, output bit tk, output logic [31:0] tg);
    int i;
    i  = int'((pc >> 2) % 16);
    tk = bv[i] && (btag[i] == (pc >> 6)) && (bctr[i] >= 2);
    tg = tk ? btgt[i] : pc + 32'd4;
  endtask

  task automatic btb_update(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
    int i;
    i = int'((pc >> 2) % 16);
    if (bv[i] && btag[i] == (pc >> 6)) begin
      if (tk) begin btgt[i] = tgt; if (bctr[i] < 3) bctr[i]++; end
      else if (bctr[i] > 0) bctr[i]--;
    end else if (tk) begin
      bv[i] = 1; btag[i] = pc >> 6; btgt[i] = tgt; bctr[i] = 2;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 0; redirect_valid = 0; btb_upd_valid = 0; imem_rsp_valid = 0;
    imem_req_ready = 0; id_ready = 0;
    repeat (n) begin
      @(negedge clk); #1;
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_id_valid", id_valid, 0);
    end
    exp_q.delete(); mem_q.delete();
    m_pc = RESET_PC; m_drop = 0; last_issue = 0;
    for (int i = 0; i < 16; i++) begin bv[i] = 0; bctr[i] = 0; end
    rst_n = 1;
  endtask

  task automatic step();
    bit exp_rv, tk;
    logic [31:0] tg, a;
    @(negedge clk);
    imem_rsp_valid = 0;
    imem_rsp_data  = $urandom();
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1;
      imem_rsp_data  = memf(mem_q[0].addr);
      void'(mem_q.pop_front());
    end
    if (d_use) begin
      redirect_valid = d_redir; redirect_pc = d_rpc;
      btb_upd_valid = d_upd; btb_upd_pc = d_upc; btb_upd_target = d_utgt; btb_upd_taken = d_utk;
      d_use = 0;
    end else begin
      redirect_valid = $urandom_range(0, 99) < p_redir;
      redirect_pc    = $urandom_range(32'h40, 32'h1ff);
      btb_upd_valid  = $urandom_range(0, 99) < p_btb;
      btb_upd_pc     = $urandom_range(16, 127) << 2;
      btb_upd_target = $urandom_range(16, 127) << 2;
      btb_upd_taken  = $urandom_range(0, 2) != 0;
    end
    id_ready       = $urandom_range(0, 99) < p_idr;
    imem_req_ready = $urandom_range(0, 99) < p_mrdy;
    #1;
    exp_rv = !redirect_valid && m_drop == 0 && exp_q.size() < QDEPTH;
    chk("req_valid", imem_req_valid, exp_rv);
    if (redirect_valid) chk("id_valid_on_redirect", id_valid, 0);
    if (imem_req_valid && imem_req_ready) begin
      a = {m_pc[31:2], 2'b00};
      chk("req_addr", imem_req_addr, a);
      issues++;
      mem_q.push_back('{addr: a, due: cyc + int'($urandom_range(1, max_lat))});
      predict(m_pc, tk, tg);
      exp_q.push_back('{pc: m_pc, ins: memf(a), taken: tk, tgt: tg});
      if (last_issue == 32'h48 && a == 32'h200) saw_200 = 1;
      if (last_issue == 32'h48 && a == 32'h4c)  saw_4c  = 1;
      last_issue = a;
      m_pc = tg;
    end
    if (imem_rsp_valid && m_drop > 0) m_drop--;
    if (redirect_valid) begin
      m_pc = {redirect_pc[31:2], 2'b00};
      exp_q.delete();
      m_drop = mem_q.size();
    end
    if (btb_upd_valid) btb_update(btb_upd_pc, btb_upd_target, btb_upd_taken);
    cyc++;
  endtask

  // decode-side monitor: every accepted instruction must match the scoreboard head
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && id_valid && id_ready) begin
      handshakes++;
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL id_unexpected: got pc %0h ins %0h, expected no instruction", id_pc, id_ins);
      end else begin
        e = exp_q.pop_front();
        chk("id_entry", {id_pc, id_ins, id_predict_taken, id_predict_target},
                        {e.pc, e.ins, e.taken, e.tgt});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    do_reset(3);

    // decode stalled: exactly QDEPTH issues, then drain and steady one-per-cycle flow
    p_idr = 0; issues = 0;
    repeat (10) step();
    chk("full_issue_count", issues, QDEPTH);
    p_idr = 100;
    repeat (30) step();
    hs0 = handshakes;
    repeat (20) step();
    chk("steady_throughput", handshakes - hs0, 20);

    // redirect with several requests in flight (long latency), restart at 0x100
    max_lat = 6;
    repeat (4) step();
    d_use = 1; d_redir = 1; d_rpc = 32'h103; d_upd = 0;
    step();
    max_lat = 1;
    repeat (25) step();

    // taken BTB entry at 0x48 -> 0x200
    d_use = 1; d_redir = 1; d_rpc = 32'h43; d_upd = 1; d_upc = 32'h48; d_utgt = 32'h200; d_utk = 1;
    step();
    saw_200 = 0;
    repeat (15) step();
    chk("btb_taken_follows_target", saw_200, 1);

    // two not-taken updates weaken the counter below the predict threshold
    d_use = 1; d_redir = 0; d_upd = 1; d_upc = 32'h48; d_utgt = 32'h0; d_utk = 0;
    step();
    d_use = 1; d_redir = 1; d_rpc = 32'h40; d_upd = 1; d_upc = 32'h48; d_utgt = 32'h0; d_utk = 0;
    step();
    saw_4c = 0;
    repeat (15) step();
    chk("btb_not_taken_falls_through", saw_4c, 1);

    // randomized traffic with a reset mid-stream
    p_redir = 3; p_btb = 10; p_idr = 70; p_mrdy = 70; max_lat = 4;
    repeat (1000) step();
    do_reset(2);
    repeat (1000) step();

    // quiesce: stop issuing and let everything outstanding drain
    p_redir = 0; p_btb = 0; p_idr = 100; p_mrdy = 0;
    repeat (30) step();
    chk("queue_drained", exp_q.size(), 0);
    chk("mem_drained", mem_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/PC width.
REQ-002 SHALL have parameter RESET_PC, default 32'h00000040, first fetch address.
REQ-003 SHALL have parameter QDEPTH, default 4, queue slots (power of 2, >=2).
REQ-004 SHALL have parameter BTB_ENTRIES, default 16, direct-mapped BTB size (power of 2, >=2).
REQ-005 SHALL have one clock; reset is asynchronous and active-low: clk in 1 (all state on posedge), rst_n in 1 (async assert, active-low).
REQ-006 SHALL have redirect_valid in 1 (flush and restart) and redirect_pc in XLEN (restart address).
REQ-007 SHALL have btb_upd_valid in 1, btb_upd_pc in XLEN, btb_upd_target in XLEN and btb_upd_taken in 1 (resolved-branch update).
REQ-008 SHALL have imem_req_valid out 1, imem_req_ready in 1 and imem_req_addr out XLEN (fetch request).
REQ-009 SHALL have imem_rsp_valid in 1 and imem_rsp_data in 32 (in-order responses, any latency >=1).
REQ-010 SHALL have id_valid out 1 and id_ready in 1 (decode handshake).
REQ-011 SHALL have id_pc out XLEN, id_ins out 32, id_predict_taken out 1 and id_predict_target out XLEN.

Function
REQ-012 SHALL keep a QDEPTH ring with three pointers: wptr (reserve at issue), fptr (fill at response), rptr (drain); each slot holds pc, ins, predict_taken, predict_target.
REQ-013 SHALL assert imem_req_valid when rst_n high, redirect_valid low, drop_cnt==0 and reserved-not-drained count <QDEPTH; imem_req_addr = pc with bits [1:0] forced to 0.
REQ-014 SHALL, on issue (imem_req_valid && imem_req_ready), write pc and the BTB prediction for pc into slot wptr, advance wptr, and set pc <= predict_taken ? predict_target : pc+4 (XLEN wrap).
REQ-015 SHALL hold pc and wptr stable while imem_req_valid && !imem_req_ready.
REQ-016 SHALL, on imem_rsp_valid with drop_cnt==0, store imem_rsp_data into slot fptr and advance fptr; a response arriving with no unfilled slot is a protocol error, ignored.
REQ-017 SHALL drive id_valid = (rptr!=fptr) && !redirect_valid, with id_* taken from slot rptr; rptr advances on id_valid && id_ready.
REQ-018 SHALL support simultaneous issue, fill and drain in one cycle; full queue with id_ready high sustains one issue per cycle.
REQ-019 SHALL, on redirect_valid, set pc <= {redirect_pc[XLEN-1:2],2'b00}, set wptr=fptr=rptr=0, and set drop_cnt <= (wptr-fptr) minus 1 if imem_rsp_valid that cycle.
REQ-020 SHALL, while drop_cnt!=0, discard each imem_rsp_valid and decrement drop_cnt; a new redirect during draining adds the newly unfilled count to the remaining drop_cnt.
REQ-021 SHALL give redirect priority over issue, fill and drain in the same cycle.
REQ-022 SHALL index the BTB with pc[log2(BTB_ENTRIES)+1:2] and use the remaining upper bits as tag; each entry holds valid, tag, target and a 2-bit saturating counter.
REQ-023 SHALL predict taken iff valid && tag match && counter[1]; predict_target = entry target, else predict_target = pc+4.
REQ-024 SHALL, on btb_upd_valid with a tag hit: rewrite target if taken, counter +1 if taken, -1 if not (saturating 0..3).
REQ-025 SHALL, on btb_upd_valid with a miss: allocate only if taken (valid=1, tag, target, counter=2'b10); a not-taken miss leaves the entry unchanged.
REQ-026 SHALL make a BTB update visible to lookups from the next cycle on; a same-cycle lookup sees old contents.
REQ-027 SHALL give latency from issue to id_valid of response latency + 1 cycle at minimum (fill registered, drain reads the filled slot next cycle).

Reset
REQ-028 SHALL, while rst_n low, force pc=RESET_PC, all pointers 0, drop_cnt=0, all BTB valid=0, id_valid=0 and imem_req_valid=0.
REQ-029 SHALL issue the first request at RESET_PC on the first posedge after rst_n deasserts; reset asserted mid-operation discards all queued and in-flight state, and responses after release are not dropped.

Verification
REQ-030 Reset release, imem always ready, 1-cycle latency, id_ready=1 -> addresses 0x40,0x44,0x48... in order; id_pc matches, with one id_valid per cycle steady state.
REQ-031 id_ready=0, QDEPTH=4 -> exactly 4 issues then imem_req_valid=0; id_ready=1 -> 4 entries drain in order and issue resumes.
REQ-032 3 requests in flight, redirect_pc=0x103 -> drop_cnt=3, next 3 responses discarded, then first issue addr=0x100 and first id_pc=0x100.
REQ-033 BTB update pc=0x48, target=0x200, taken -> next fetch of 0x48 gives id_predict_taken=1, target 0x200, and the following issue addr=0x200.
REQ-034 Two not-taken updates at 0x48 after REQ-033 -> counter 2->1->0, and the next fetch of 0x48 predicts not-taken with following addr=0x4C.
REQ-035 Redirect in the same cycle as a response and an id handshake -> the response is counted as dropped, id_valid=0 that cycle, and the queue is empty next cycle.
